// File: rtl/fetch_seq_pkg.sv
// Shared types and defaults for the fetch sequencer.
// Defining FETCH_TIMEOUT_EN adds the FAULT state.
package fetch_seq_pkg;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
    localparam int unsigned DEF_CNT_W          = 16;
    localparam int unsigned TMO_W              = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        RESOLVE,
        UPDATE
`ifdef FETCH_TIMEOUT_EN
        , FAULT
`endif
    } state_t;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the performance counters.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue/resolve/update sequencer with performance counters.
// Optional FETCH_TIMEOUT_EN adds a fetch timeout that latches into FAULT until rst.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             resolve_valid,
    input  logic             resolve_jump,
    input  logic             resolve_taken,
    input  logic             flush,
    output logic             pc_en,
    output logic             pc_jump,
    output logic             pc_branch,
    output logic             fault,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    state_t state;
    state_t state_n;
    logic   cap_jump;
    logic   cap_taken;
    logic   stall_inc;
    logic   retire_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts consecutive un-acked FETCH cycles; any other cycle restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state == FETCH) && !imem_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (enable) state_n = FETCH;
            end
            FETCH: begin
                if (imem_ack) state_n = ISSUE;
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) state_n = FAULT;
`endif
            end
            ISSUE: begin
                if (flush) state_n = enable ? FETCH : IDLE;
                else if (instr_ready) state_n = RESOLVE;
            end
            RESOLVE: begin
                if (flush) state_n = enable ? FETCH : IDLE;
                else if (resolve_valid) state_n = UPDATE;
            end
            UPDATE: begin
                state_n = enable ? FETCH : IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            FAULT: begin
                state_n = FAULT;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_jump  <= 1'b0;
            cap_taken <= 1'b0;
        end else if ((state == RESOLVE) && resolve_valid && !flush) begin
            cap_jump  <= resolve_jump;
            cap_taken <= resolve_taken;
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        pc_en       = 1'b0;
        pc_jump     = 1'b0;
        pc_branch   = 1'b0;
        fault       = 1'b0;
        unique case (state)
            FETCH:   imem_req    = 1'b1;
            ISSUE:   instr_valid = 1'b1;
            UPDATE: begin
                pc_en     = 1'b1;
                pc_jump   = cap_jump;
                pc_branch = cap_taken && !cap_jump;
            end
`ifdef FETCH_TIMEOUT_EN
            FAULT:   fault       = 1'b1;
`endif
            default: ;
        endcase
    end

    assign stall_inc  = (state == FETCH) && !imem_ack;
    assign retire_inc = (state == UPDATE);

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_retired_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (retire_inc),
        .clear(1'b0),
        .count(retired_cnt)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .clear(1'b0),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer; narrow counters expose saturation.
// Timeout checks apply when FETCH_TIMEOUT_EN is defined.
module tb_fetch_sequencer;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          imem_req;
    logic          imem_ack;
    logic          instr_valid;
    logic          instr_ready;
    logic          resolve_valid;
    logic          resolve_jump;
    logic          resolve_taken;
    logic          flush;
    logic          pc_en;
    logic          pc_jump;
    logic          pc_branch;
    logic          fault;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] stall_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .resolve_valid(resolve_valid),
        .resolve_jump (resolve_jump),
        .resolve_taken(resolve_taken),
        .flush        (flush),
        .pc_en        (pc_en),
        .pc_jump      (pc_jump),
        .pc_branch    (pc_branch),
        .fault        (fault),
        .retired_cnt  (retired_cnt),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every pc_en cycle consumes one expected {pc_jump, pc_branch}.
    always @(negedge clk) begin
        if (!rst && pc_en) begin
            if (exp_q.size() == 0) begin
                check("pc_en_unexpected", pc_en, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pc_select", {pc_jump, pc_branch}, mon_exp);
            end
        end
    end

    task automatic run_one(input logic j, input logic t, input logic [1:0] exp_sel);
        int lat;
        lat = -1;
        resolve_jump  = j;
        resolve_taken = t;
        imem_ack      = 1'b1;
        instr_ready   = 1'b1;
        resolve_valid = 1'b1;
        flush         = 1'b0;
        enable        = 1'b1;
        exp_q.push_back(exp_sel);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pc_en) begin
                lat = i;
                break;
            end
        end
        enable = 1'b0;
        check("update_latency", lat, 3);
        @(negedge clk);
        check("idle_after_update", imem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        resolve_valid = 1'b0; resolve_jump = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {imem_req, instr_valid, pc_en, pc_jump, pc_branch, fault}, 0);
        check("rst_retired", retired_cnt, 0);
        check("rst_stall", stall_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold", imem_req, 0);

        // Back-to-back instructions with immediate responses.
        imem_ack = 1'b1; instr_ready = 1'b1; resolve_valid = 1'b1; enable = 1'b1;
        repeat (3) exp_q.push_back(2'b00);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("pc_en_cadence", pc_en, ((k % 4) == 0) ? 1 : 0);
            if (k == 12) enable = 1'b0;
        end
        @(negedge clk);
        check("retired_after_12", retired_cnt, 3);
        check("stall_none", stall_cnt, 0);
        check("idle_after_run", imem_req, 0);

        // Jump/branch select: jump wins over taken.
        run_one(1'b1, 1'b1, 2'b10);
        run_one(1'b0, 1'b1, 2'b01);
        run_one(1'b1, 1'b0, 2'b10);
        check("retired_6", retired_cnt, 6);

        // Ack delayed five cycles.
        imem_ack = 1'b0; resolve_jump = 1'b0; resolve_taken = 1'b0; enable = 1'b1;
        exp_q.push_back(2'b00);
        repeat (6) @(negedge clk);
        check("fetch_waiting", imem_req, 1);
        imem_ack = 1'b1;
        @(negedge clk);
        check("stall_cnt_5", stall_cnt, 5);
        check("issue_once_a", instr_valid, 1);
        @(negedge clk);
        check("issue_once_b", instr_valid, 0);
        @(negedge clk);
        check("update_after_stall", pc_en, 1);
        enable = 1'b0;
        @(negedge clk);
        check("retired_7", retired_cnt, 7);

        // Counter saturates at all-ones.
        run_one(1'b0, 1'b0, 2'b00);
        check("retired_saturated", retired_cnt, 7);

        // Hold in ISSUE, then flush in RESOLVE and in ISSUE.
        imem_ack = 1'b1; instr_ready = 1'b0; resolve_valid = 1'b0; flush = 1'b0; enable = 1'b1;
        @(negedge clk);
        check("fetch_req", imem_req, 1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("valid_held", instr_valid, 1);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check("in_resolve", {instr_valid, pc_en, imem_req}, 0);
        flush = 1'b1; resolve_valid = 1'b1; resolve_jump = 1'b1;
        @(negedge clk);
        check("flush_to_fetch", imem_req, 1);
        check("flush_no_pc_en", pc_en, 0);
        check("flush_retired", retired_cnt, 7);
        enable = 1'b0;
        @(negedge clk);
        check("reissue", instr_valid, 1);
        @(negedge clk);
        check("flush_issue_idle", {instr_valid, imem_req, pc_en}, 0);
        flush = 1'b0;
        @(negedge clk);
        check("idle_no_update", pc_en, 0);
        resolve_jump = 1'b0;

        // Asynchronous reset while in ISSUE.
        imem_ack = 1'b1; instr_ready = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_issue", instr_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", instr_valid, 0);
        check("rst_async_req", imem_req, 0);
        check("rst_async_retired", retired_cnt, 0);
        check("rst_async_stall", stall_cnt, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Fetch without any ack.
        imem_ack = 1'b0; enable = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        repeat (16) @(negedge clk);
        check("pre_timeout_fault", fault, 0);
        check("pre_timeout_req", imem_req, 1);
        @(negedge clk);
        check("timeout_fault", fault, 1);
        check("timeout_req", imem_req, 0);
        check("stall_saturated", stall_cnt, 7);
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("fault_held", fault, 1);
        check("fault_quiet", {imem_req, instr_valid, pc_en}, 0);
`else
        repeat (40) @(negedge clk);
        check("wait_forever_req", imem_req, 1);
        check("no_fault", fault, 0);
        check("stall_saturated", stall_cnt, 7);
`endif
        rst = 1'b1;
        #1;
        check("rst_clears_fault", fault, 0);
        check("rst_clears_req", imem_req, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {imem_req, fault}, 0);

        check("scoreboard_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum FETCH wait in cycles (range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of both performance counters.
REQ-003 The block SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 The block SHALL have port enable, input, 1, permits starting a new fetch.
REQ-006 The block SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-007 The block SHALL have port imem_ack, input, 1, instruction-memory data valid.
REQ-008 The block SHALL have port instr_valid, output, 1, instruction offered to decode.
REQ-009 The block SHALL have port instr_ready, input, 1, decode accepts instruction.
REQ-010 The block SHALL have port resolve_valid, input, 1, execute has resolved control flow.
REQ-011 The block SHALL have port resolve_jump, input, 1, resolved instruction is a jump.
REQ-012 The block SHALL have port resolve_taken, input, 1, resolved branch is taken.
REQ-013 The block SHALL have port flush, input, 1, abandon current instruction without PC update.
REQ-014 The block SHALL have port pc_en, output, 1, PC register update strobe.
REQ-015 The block SHALL have port pc_jump, output, 1, selects jump target at PC.
REQ-016 The block SHALL have port pc_branch, output, 1, selects PC-relative branch at PC.
REQ-017 The block SHALL have port fault, output, 1, fetch timeout fault.
REQ-018 The block SHALL have port retired_cnt, output, CNT_W, count of completed UPDATE cycles.
REQ-019 The block SHALL have port stall_cnt, output, CNT_W, count of FETCH cycles with imem_ack=0.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, ISSUE, RESOLVE, UPDATE and FAULT; all outputs SHALL be Moore-decoded from the state register.
REQ-021 In IDLE, enable=1 SHALL move the FSM to FETCH; otherwise it SHALL hold.
REQ-022 FETCH SHALL assert imem_req; sampled imem_ack=1 SHALL move the FSM to ISSUE.
REQ-023 ISSUE SHALL assert instr_valid; instr_ready=1 SHALL move the FSM to RESOLVE; instr_valid SHALL NOT drop before acceptance.
REQ-024 RESOLVE SHALL capture resolve_jump and resolve_taken on resolve_valid=1 and move to UPDATE.
REQ-025 UPDATE SHALL assert pc_en for exactly 1 cycle, with pc_jump=captured jump and pc_branch=captured taken AND NOT captured jump; jump wins when both are set.
REQ-026 With both captured flags 0, UPDATE SHALL assert pc_en alone (sequential PC+1).
REQ-027 After UPDATE the FSM SHALL go to FETCH if enable=1, else to IDLE.
REQ-028 flush=1 in ISSUE or RESOLVE SHALL go to FETCH (enable=1) or IDLE, with no pc_en and no retired_cnt increment; flush SHALL have priority over instr_ready and resolve_valid; flush SHALL be ignored in other states.
REQ-029 Minimum latency SHALL be 4 cycles per instruction (FETCH, ISSUE, RESOLVE, UPDATE) when all responses occur in the first cycle.
REQ-030 retired_cnt SHALL increment on each UPDATE cycle; stall_cnt SHALL increment on each FETCH cycle with imem_ack=0; both SHALL saturate at all-ones and not wrap.
REQ-031 imem_ack outside FETCH and resolve_valid outside RESOLVE SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE, zero both counters, clear the captured flags and the timeout counter, and drive imem_req, instr_valid, pc_en, pc_jump, pc_branch and fault to 0 immediately, including mid-transaction.

Configuration
REQ-033 With FETCH_TIMEOUT_EN defined, a counter SHALL run during FETCH; reaching TIMEOUT_CYCLES consecutive FETCH cycles without ack SHALL enter FAULT, which holds fault=1, all other outputs 0, and exits only on rst.
REQ-034 Without FETCH_TIMEOUT_EN, the timeout logic and FAULT state SHALL be absent, fault SHALL be tied to 0, and FETCH SHALL wait indefinitely.

Structure
REQ-035 Package fetch_seq_pkg SHALL hold the state enum and the default TIMEOUT_CYCLES and CNT_W constants.
REQ-036 A sub-module sat_counter (parameterised width, inc, clear, saturating) SHALL implement both performance counters.

Verification
REQ-038 A bench SHALL cover: enable=1 with immediate ack, ready and resolve (no jump/taken) -> pc_en pulses every 4 cycles, pc_jump=pc_branch=0, retired_cnt=3 after 12 cycles.
REQ-039 A bench SHALL cover: resolve_jump=1 and resolve_taken=1 together -> UPDATE with pc_jump=1, pc_branch=0.
REQ-040 A bench SHALL cover: ack delayed 5 cycles -> stall_cnt=5, single ISSUE follows.
REQ-041 A bench SHALL cover: flush in RESOLVE -> no pc_en, retired_cnt unchanged, FETCH next cycle.
REQ-042 A bench SHALL cover: FETCH_TIMEOUT_EN defined with no ack for 16 cycles -> fault=1 and held; rst -> fault=0, IDLE.
REQ-043 A bench SHALL cover: rst asserted during ISSUE -> instr_valid=0 in the same cycle, counters 0.
